// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the RAM port arbiter
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int ID_W_MAX   = 3;

    typedef enum logic {ST_INIT, ST_RUN} arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [ID_W_MAX-1:0]   id;
    } ram_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search
// Ports:
//   req      per-requester request vector
//   ptr      index where the search starts (highest priority this cycle)
//   gnt      one-hot grant
//   gnt_idx  index of the granted requester
//   any      at least one request present
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);

    int idx;

    // Walk upward from ptr with wrap; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin sharing of one single-port RAM
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready/req_we          per-requester command handshake
//   req_addr/req_wdata                  packed per-requester command fields
//   rsp_valid/rsp_id/rsp_rdata          read response, fixed 3-cycle latency
//   init_done                           clear sweep finished (sticky)
//   mem_we/mem_write_addr/mem_read_addr/mem_data/mem_q   RAM interface
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic                      rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      init_done,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_write_addr,
    output logic [ADDR_W-1:0]         mem_read_addr,
    output logic [DATA_W-1:0]         mem_data,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int ID_W = $clog2(N_REQ);
    // Counter runs one past the last address so the final sweep write is
    // still on the port when the FSM leaves INIT.
    localparam logic [ADDR_W:0] INIT_END = {1'b1, {ADDR_W{1'b0}}};

    arb_state_t        state, state_nx;
    logic [ADDR_W:0]   init_cnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              accept;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Read tracking: iss_* aligns with the address on the RAM port,
    // p1_* aligns with mem_q.
    logic              iss_rd;
    logic [ID_W-1:0]   iss_id;
    logic              p1_rd;
    logic [ID_W-1:0]   p1_id;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign cmd_we    = req_we[gnt_idx];
    assign cmd_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign cmd_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_END) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = gnt;
                accept    = gnt_any;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt       <= '0;
            init_done      <= 1'b0;
            rr_ptr         <= '0;
            mem_we         <= 1'b0;
            mem_write_addr <= '0;
            mem_read_addr  <= '0;
            mem_data       <= '0;
            iss_rd         <= 1'b0;
            iss_id         <= '0;
            p1_rd          <= 1'b0;
            p1_id          <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_rdata      <= '0;
        end else begin
            iss_rd <= 1'b0;
            if (state == ST_INIT) begin
                if (init_cnt == INIT_END) begin
                    mem_we    <= 1'b0;
                    init_done <= 1'b1;
                end else begin
                    mem_we         <= 1'b1;
                    mem_write_addr <= init_cnt[ADDR_W-1:0];
                    mem_data       <= '0;
                    init_cnt       <= init_cnt + 1'b1;
                end
            end else begin
                mem_we <= accept & cmd_we;
                if (accept) begin
                    iss_rd <= ~cmd_we;
                    iss_id <= gnt_idx;
                    if (cmd_we) begin
                        mem_write_addr <= cmd_addr;
                        mem_data       <= cmd_wdata;
                    end else begin
                        mem_read_addr  <= cmd_addr;
                    end
                    rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            p1_rd     <= iss_rd;
            p1_id     <= iss_id;
            rsp_valid <= p1_rd;
            if (p1_rd) begin
                rsp_id    <= p1_id;
                rsp_rdata <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic                     clk;
    logic                     rst_n;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         req_we;
    logic [N_REQ*ADDR_W-1:0]  req_addr;
    logic [N_REQ*DATA_W-1:0]  req_wdata;
    logic                     rsp_valid;
    logic [0:0]               rsp_id;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     init_done;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_write_addr;
    logic [ADDR_W-1:0]        mem_read_addr;
    logic [DATA_W-1:0]        mem_data;
    logic [DATA_W-1:0]        mem_q;

    ram_port_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .mem_we         (mem_we),
        .mem_write_addr (mem_write_addr),
        .mem_read_addr  (mem_read_addr),
        .mem_data       (mem_data),
        .mem_q          (mem_q)
    );

    // Single-port RAM model, preloaded with garbage so the sweep is visible.
    logic [DATA_W-1:0] ram [0:63];
    logic [ADDR_W-1:0] ra_q;
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'hEE;
        ra_q = '0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_write_addr] <= mem_data;
        ra_q <= mem_read_addr;
    end
    assign mem_q = ram[ra_q];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int           id;
        logic [7:0]   data;
        int           due;
    } exp_t;

    exp_t        sb [$];
    int          glog [$];
    logic [7:0]  shadow [0:63];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          we_viol = 0;
    logic        acc_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        acc_prev <= init_done && (|(req_valid & req_ready));
    end

    // Monitor: every response must match the head of the scoreboard,
    // including the cycle it was due in.
    always @(negedge clk) begin
        if (init_done && !acc_prev && mem_we) we_viol++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_rdata), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                chk("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(input int id, input bit we, input logic [5:0] a, input logic [7:0] d,
                         input bit has_exp, input logic [7:0] expd, input bit push);
        int waited;
        exp_t e;
        waited = 0;
        req_we[id]           = we;
        req_addr[id*6 +: 6]  = a;
        req_wdata[id*8 +: 8] = d;
        req_valid[id]        = 1'b1;
        #1;
        while (!req_ready[id]) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 200) begin
                chk("accept_timeout", 32'(id), 32'hFFFF);
                req_valid[id] = 1'b0;
                return;
            end
        end
        glog.push_back(id);
        if (we) begin
            shadow[a] = d;
        end else if (push) begin
            e.id   = id;
            e.data = has_exp ? expd : shadow[a];
            e.due  = cyc + 3;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic sweep_check();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("init_we", 32'(mem_we), 32'd1);
            chk("init_addr", 32'(mem_write_addr), 32'(k));
            chk("init_data", 32'(mem_data), 32'd0);
            chk("init_ready", 32'(req_ready), 32'd0);
            chk("init_done_low", 32'(init_done), 32'd0);
        end
        @(negedge clk);
        chk("init_done_rise", 32'(init_done), 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_waddr", 32'(mem_write_addr), 32'd0);
        chk("rst_mem_raddr", 32'(mem_read_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();

        // 1: sweep, with requester 0 holding a read during INIT
        rst_n = 1'b1;
        fork
            sweep_check();
            issue(0, 1'b0, 6'h05, 8'h00, 1'b1, 8'h00, 1'b1);
        join
        chk("run_idle_we", 32'(mem_we), 32'd0);
        drain();

        // 2: single path
        issue(0, 1'b1, 6'h00, 8'hAA, 1'b0, 8'h00, 1'b0);
        issue(0, 1'b0, 6'h00, 8'h00, 1'b1, 8'hAA, 1'b1);
        drain();
        issue(1, 1'b0, 6'h00, 8'h00, 1'b1, 8'hAA, 1'b1);
        drain();

        // 3: contention, pointer now at 0
        glog.delete();
        fork
            begin
                issue(0, 1'b1, 6'h3F, 8'h55, 1'b0, 8'h00, 1'b0);
                issue(0, 1'b0, 6'h3F, 8'h00, 1'b1, 8'h55, 1'b1);
            end
            begin
                issue(1, 1'b1, 6'h01, 8'h11, 1'b0, 8'h00, 1'b0);
                issue(1, 1'b0, 6'h01, 8'h00, 1'b1, 8'h11, 1'b1);
            end
        join
        chk("grant_count", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            chk("grant0", 32'(glog[0]), 32'd0);
            chk("grant1", 32'(glog[1]), 32'd1);
            chk("grant2", 32'(glog[2]), 32'd0);
            chk("grant3", 32'(glog[3]), 32'd1);
        end
        drain();

        // 4: write then read of the same address in consecutive cycles
        fork
            issue(1, 1'b1, 6'h0A, 8'hFF, 1'b0, 8'h00, 1'b0);
            begin
                @(negedge clk);
                issue(0, 1'b0, 6'h0A, 8'h00, 1'b1, 8'hFF, 1'b1);
            end
        join
        drain();

        // 5: reset one cycle after a read is accepted
        issue(0, 1'b0, 6'h0A, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        rst_n = 1'b1;
        sweep_check();
        issue(0, 1'b0, 6'h0A, 8'h00, 1'b1, 8'h00, 1'b1);
        drain();

        // 6: random gaps, expectations from the shadow memory
        fork
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                issue(0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                      8'($urandom), 1'b0, 8'h00, 1'b1);
            end
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                issue(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                      8'($urandom), 1'b0, 8'h00, 1'b1);
            end
        join
        drain();
        chk("idle_mem_we", 32'(we_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
